se_lfsr_counter_64: RTL and testbench

- Synchronous up-counter, default 64 bits, built for high clock rate.
- Low 4 bits are a state-extended (de Bruijn) LFSR prescaler covering all 16 states. Upper WIDTH-4 bits are a binary counter advanced by the prescaler's registered carry.
- Out presents the plain binary count.
- Used as a free-running event/cycle counter in timing and power-measurement datapaths.

---
 rtl/se_counter_pkg.sv | 12 +
 rtl/se_lfsr_prescaler.sv | 25 ++
 rtl/se_lfsr_counter_64.sv | 37 +++
 tb/tb_se_lfsr_counter_64.sv | 138 +++++++++++++
 4 files changed

// File: rtl/se_counter_pkg.sv
// se_counter_pkg: shared constants, LFSR-to-binary decode table and LFSR next-state function
package se_counter_pkg;
  localparam int PRE_W = 4;
  localparam logic [PRE_W-1:0] TERM_STATE = 4'h8;
  localparam logic [PRE_W-1:0] DEC_TAB [16] = '{
    4'd0, 4'd1, 4'd2, 4'd5, 4'd3, 4'd9, 4'd6, 4'd11,
    4'd15, 4'd4, 4'd8, 4'd10, 4'd14, 4'd7, 4'd13, 4'd12
  };
  function automatic logic [PRE_W-1:0] lfsr_next(input logic [PRE_W-1:0] s);
    return {s[2:0], s[3] ^ s[2] ^ (s[2:0] == 3'b000)};
  endfunction
endpackage

// File: rtl/se_lfsr_prescaler.sv
// se_lfsr_prescaler: 16-state de Bruijn LFSR prescaler with a registered terminal flag
module se_lfsr_prescaler
  import se_counter_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             CNT,
  output logic [PRE_W-1:0] state,
  output logic             carry
);
  logic             term;
  logic [PRE_W-1:0] nxt;
  // term is precomputed a cycle early so the carry is a single AND off a flop
  assign carry = CNT & term;
  always_comb nxt = carry ? '0 : lfsr_next(state);
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= '0;
      term  <= 1'b0;
    end else if (CNT) begin
      state <= nxt;
      term  <= (nxt == TERM_STATE);
    end
  end
endmodule

// File: rtl/se_lfsr_counter_64.sv
// se_lfsr_counter_64: LFSR-prescaled binary up-counter; OVF_FLAG_EN adds a sticky wrap flag Ovf
module se_lfsr_counter_64
  import se_counter_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             CNT,
`ifdef OVF_FLAG_EN
  output logic             Ovf,
`endif
  output logic [WIDTH-1:0] Out
);
  localparam int UW = WIDTH - PRE_W;
  logic [PRE_W-1:0] state;
  logic             carry;
  logic [UW-1:0]    upper;
  se_lfsr_prescaler u_pre (
    .Clk  (Clk),
    .Rst  (Rst),
    .CNT  (CNT),
    .state(state),
    .carry(carry)
  );
  always_ff @(posedge Clk) begin
    if (Rst) upper <= '0;
    else if (carry) upper <= upper + UW'(1);
  end
  assign Out = {upper, DEC_TAB[state]};
`ifdef OVF_FLAG_EN
  always_ff @(posedge Clk) begin
    if (Rst) Ovf <= 1'b0;
    else if (carry && &upper) Ovf <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_se_lfsr_counter_64.sv
// tb_se_lfsr_counter_64: directed vector bench for 64-bit and 8-bit counter instances
module tb_se_lfsr_counter_64;
  typedef struct {
    logic        rst;
    logic        cnt;
    logic [63:0] exp;
  } vec_t;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        CNT = 1'b1;
  logic [63:0] out64;
  logic [7:0]  out8;
  logic [63:0] m = '0;
  int          checks = 0;
  int          failures = 0;
  vec_t        tv [14];
  logic [3:0]  seq [16] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD,
                            4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
`ifdef OVF_FLAG_EN
  logic ovf64, ovf8;
`endif
  always #5 Clk = ~Clk;
  se_lfsr_counter_64 dut64 (
    .Clk(Clk),
    .Rst(Rst),
    .CNT(CNT),
`ifdef OVF_FLAG_EN
    .Ovf(ovf64),
`endif
    .Out(out64)
  );
  se_lfsr_counter_64 #(.WIDTH(8)) dut8 (
    .Clk(Clk),
    .Rst(Rst),
    .CNT(CNT),
`ifdef OVF_FLAG_EN
    .Ovf(ovf8),
`endif
    .Out(out8)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic c);
    Rst = r;
    CNT = c;
    @(posedge Clk);
    #1;
    m = r ? 64'd0 : (c ? m + 64'd1 : m);
  endtask
  task automatic both(input string name);
    chk({name, "_out64"}, out64, m);
    chk({name, "_out8"}, {56'd0, out8}, {56'd0, m[7:0]});
  endtask
  initial begin
    tv[0]  = '{1'b0, 1'b1, 64'd1};
    tv[1]  = '{1'b0, 1'b1, 64'd2};
    tv[2]  = '{1'b0, 1'b1, 64'd3};
    tv[3]  = '{1'b0, 1'b0, 64'd3};
    tv[4]  = '{1'b0, 1'b0, 64'd3};
    tv[5]  = '{1'b0, 1'b1, 64'd4};
    tv[6]  = '{1'b0, 1'b1, 64'd5};
    tv[7]  = '{1'b1, 1'b1, 64'd0};
    tv[8]  = '{1'b0, 1'b0, 64'd0};
    tv[9]  = '{1'b0, 1'b1, 64'd1};
    tv[10] = '{1'b1, 1'b0, 64'd0};
    tv[11] = '{1'b0, 1'b1, 64'd1};
    tv[12] = '{1'b0, 1'b1, 64'd2};
    tv[13] = '{1'b0, 1'b0, 64'd2};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      chk("reset_out64", out64, 64'd0);
      chk("reset_out8", {56'd0, out8}, 64'd0);
    end
    for (int i = 0; i < 14; i++) begin
      step(tv[i].rst, tv[i].cnt);
      chk($sformatf("vec%0d_out64", i), out64, tv[i].exp);
      chk($sformatf("vec%0d_out8", i), {56'd0, out8}, {56'd0, tv[i].exp[7:0]});
    end
    step(1'b1, 1'b0);
    chk("lfsr_reset", {60'd0, dut64.u_pre.state}, 64'd0);
    for (int i = 1; i <= 50; i++) begin
      step(1'b0, 1'b1);
      chk($sformatf("run%0d", i), out64, 64'(i));
      chk($sformatf("run%0d_upper", i), {4'd0, out64[63:4]}, 64'(i / 16));
      if (i < 32) chk($sformatf("lfsr%0d", i), {60'd0, dut64.u_pre.state}, {60'd0, seq[i % 16]});
    end
    chk("run_final", out64, 64'h32);
    step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    chk("hold_start", out64, 64'd20);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0);
      chk("hold", out64, 64'd20);
    end
    step(1'b0, 1'b1);
    chk("hold_resume", out64, 64'd21);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
    chk("pre_midrst", out64, 64'd37);
    step(1'b1, 1'b1);
    chk("midrst", out64, 64'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b1);
      chk("midrst_after", out64, 64'(i));
    end
    step(1'b1, 1'b0);
    for (int i = 0; i < 255; i++) step(1'b0, 1'b1);
    chk("wrap_pre8", {56'd0, out8}, 64'd255);
`ifdef OVF_FLAG_EN
    chk("ovf_pre", {63'd0, ovf8}, 64'd0);
`endif
    step(1'b0, 1'b1);
    chk("wrap8", {56'd0, out8}, 64'd0);
    chk("wrap64", out64, 64'd256);
`ifdef OVF_FLAG_EN
    chk("ovf_set", {63'd0, ovf8}, 64'd1);
    chk("ovf64_clear", {63'd0, ovf64}, 64'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      both("post_wrap");
`ifdef OVF_FLAG_EN
      chk("ovf_sticky", {63'd0, ovf8}, 64'd1);
`endif
    end
    step(1'b1, 1'b0);
    both("final_rst");
`ifdef OVF_FLAG_EN
    chk("ovf_rst", {63'd0, ovf8}, 64'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
